uart_word_transmitter: RTL
==========================

UART_WORD_TRANSMITTER -- requirements
Module: uart_word_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, number of 16-bit words buffered; power of two, >= 2.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  16  word to transmit, sampled when in_valid && in_ready.
REQ-006 in_valid  input  1  producer offers in_data this cycle.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle (registered, = FIFO not full).
REQ-008 tx  output  1  UART serial line, 8N1, idle high, registered.
REQ-009 busy  output  1  high while the FIFO holds any word or a frame is in progress.

Function
REQ-010 Handshake: a word SHALL be written into the FIFO on every edge where in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored with no loss of stored data.
REQ-011 in_ready SHALL be derived from the registered occupancy count; a same-cycle pop SHALL NOT raise in_ready in the cycle the FIFO is full.
REQ-012 Simultaneous push and pop SHALL leave occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-013 Each word SHALL be sent as two 8N1 bytes, low byte in_data[7:0] first, then high byte in_data[15:8], each byte LSB first.
REQ-014 FSM states: IDLE, START, DATA, STOP; a byte-select flag SHALL track low/high byte.
REQ-015 IDLE: tx=1; when FIFO non-empty, pop one word, load the low byte, tx<=0, go to START.
REQ-016 START: hold tx=0 for CLKS_PER_BIT cycles, then drive bit 0, go to DATA.
REQ-017 DATA: hold each bit CLKS_PER_BIT cycles; after bit 7, tx<=1, go to STOP.
REQ-018 STOP: hold tx=1 for CLKS_PER_BIT cycles; then if low byte was sent, load high byte and go to START with no idle gap; else if FIFO non-empty, pop next word and go to START directly; else go to IDLE.
REQ-019 Every bit period SHALL be exactly CLKS_PER_BIT cycles; one word frame SHALL occupy exactly 20*CLKS_PER_BIT cycles; back-to-back words SHALL have no idle cycles between frames.
REQ-020 Latency: word accepted into an empty, idle block at edge N SHALL produce tx=0 after edge N+1.
REQ-021 Bit counter 3 bits, baud counter width ceil(log2(CLKS_PER_BIT)); counters SHALL reset to 0 at each state/bit transition.
REQ-022 busy SHALL be 0 only when state=IDLE and FIFO empty.
REQ-023 Data stored in the FIFO SHALL be transmitted in acceptance order, bit-exact.

Reset
REQ-024 While reset=1: tx=1, busy=0, in_ready=1 (from the next edge), state=IDLE, FIFO occupancy 0, pointers 0, counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame and discard all buffered words; tx SHALL be 1 after that edge; in_valid during reset SHALL be ignored.
REQ-026 After reset release, the first accepted word SHALL begin with a full-length start bit.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 Single word 0xA55A pushed at edge N -> tx low after N+1; bit stream 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 80 cycles total; busy falls after final stop bit.
REQ-028 Push 6 words on consecutive cycles from idle -> words 0..4 accepted, in_ready low after 5th acceptance, 6th held until in_ready returns; all accepted words appear on tx in order with no inter-frame idle.
REQ-029 in_valid=0 for 200 cycles after reset -> tx constantly 1, busy 0, in_ready 1.
REQ-030 Reset asserted during DATA of the high byte with 2 words queued -> tx=1 after that edge, busy 0, no further start bits until a new word is pushed.
REQ-031 Loopback: tx into the existing UART receiver at matching baud, 100 random words -> receiver out_valid pulses 100 times with identical 16-bit values.
REQ-032 Full FIFO with pop and in_valid in same cycle -> push refused that cycle, accepted next cycle, no corruption.

Source files
------------

// File: rtl/uart_word_transmitter.sv
// uart_word_transmitter: buffers 16-bit words in a small FIFO and sends each
// word as two back-to-back 8N1 UART bytes, low byte first, LSB first.
`timescale 1ns/1ps
module uart_word_transmitter #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        tx,
   output logic        busy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [15:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             push;
   logic             pop;
   logic             empty;
   logic [15:0]      head;

   // Serializer state
   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic [7:0]        high_byte;
   logic              byte_sel;   // 0: low byte in flight, 1: high byte in flight
   logic              baud_done;

   assign empty     = (count == '0);
   assign push      = in_valid && in_ready;
   assign head      = mem[rd_ptr];
   assign baud_done = (baud_cnt == BAUD_LAST);
   assign busy      = !((state == IDLE) && empty);

   // Pop whenever the serializer is about to start a new word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      pop = 1'b0;
      case (state)
         IDLE:    pop = !empty;
         STOP:    pop = baud_done && byte_sel && !empty;
         default: pop = 1'b0;
      endcase
   end

   // Next occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // FIFO pointers, occupancy and registered ready flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_next;
         in_ready <= (count_next != FULL_COUNT);
      end
   end

   // FIFO storage write.
   always_ff @(posedge clock) begin
      // NOTE: the storage array is deliberately left unreset; the pointers and
      // occupancy define which entries are valid, so resetting it buys nothing.
      if (push) mem[wr_ptr] <= in_data;
   end

   // Serializer FSM: start bit, eight data bits LSB first, stop bit, twice per word.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         high_byte <= '0;
         byte_sel  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (!empty) begin
                  shift     <= head[7:0];
                  high_byte <= head[15:8];
                  byte_sel  <= 1'b0;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end

            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shift[0];
                  shift    <= shift >> 1;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (!byte_sel) begin
                     // Low byte done: follow immediately with the high byte.
                     shift    <= high_byte;
                     byte_sel <= 1'b1;
                     tx       <= 1'b0;
                     state    <= START;
                  end else if (!empty) begin
                     // Word done and another is waiting: no idle gap.
                     shift     <= head[7:0];
                     high_byte <= head[15:8];
                     byte_sel  <= 1'b0;
                     tx        <= 1'b0;
                     state     <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
